// File: rtl/msgdma_sink_fifo_if.sv
// rtl/msgdma_sink_fifo_if.sv - stream in/out and status window signals of the sink FIFO
interface msgdma_sink_fifo_if;
    logic        snk_valid;
    logic [31:0] snk_data;
    logic        snk_eop;
    logic        snk_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic [1:0]  address;
    logic [31:0] readdata;

    modport slave (
        input  snk_valid, snk_data, snk_eop, out_ready, address,
        output snk_ready, out_valid, out_data, out_last, readdata
    );

    modport master (
        output snk_valid, snk_data, snk_eop, out_ready, address,
        input  snk_ready, out_valid, out_data, out_last, readdata
    );
endinterface

// File: rtl/msgdma_sink_fifo.sv
// rtl/msgdma_sink_fifo.sv - show-ahead FIFO between mSGDMA stream source and CORDIC, with status counters
module msgdma_sink_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   clr,
    msgdma_sink_fifo_if.slave      bus
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [32:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              in_pkt_q;
    logic [31:0]       word_cnt_q, pkt_cnt_q, stall_cnt_q;
    logic [31:0]       readdata_q, readdata_d;

    logic full, empty, push, pop, stall;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    assign bus.snk_ready = !full && !clr;
    assign bus.out_valid = !empty;
    assign {bus.out_last, bus.out_data} = mem_q[rd_ptr_q];
    assign bus.readdata  = readdata_q;

    // clr blocks push through snk_ready; pop is gated here so clear always wins
    assign push  = bus.snk_valid && bus.snk_ready;
    assign pop   = bus.out_valid && bus.out_ready && !clr;
    assign stall = bus.snk_valid && !bus.snk_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            2'd0:    readdata_d = {13'b0, in_pkt_q, full, empty, 7'b0, 9'(count_q)};
            2'd1:    readdata_d = word_cnt_q;
            2'd2:    readdata_d = pkt_cnt_q;
            default: readdata_d = stall_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.snk_eop, bus.snk_data};
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_pkt_q    <= 1'b0;
            word_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
            readdata_q  <= '0;
        end else begin
            readdata_q <= readdata_d;
            if (clr) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                in_pkt_q    <= 1'b0;
                word_cnt_q  <= '0;
                pkt_cnt_q   <= '0;
                stall_cnt_q <= '0;
            end else begin
                count_q <= count_d;
                if (push) begin
                    wr_ptr_q   <= wr_ptr_q + 1'b1;
                    word_cnt_q <= word_cnt_q + 1'b1;
                    in_pkt_q   <= !bus.snk_eop;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    if (bus.out_last) begin
                        pkt_cnt_q <= pkt_cnt_q + 1'b1;
                    end
                end
                if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                    stall_cnt_q <= stall_cnt_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_msgdma_sink_fifo.sv
// tb/tb_msgdma_sink_fifo.sv - scoreboard bench for msgdma_sink_fifo
module tb_msgdma_sink_fifo;
    logic clk = 1'b0;
    logic aclr_n;
    logic clr;

    msgdma_sink_fifo_if bus ();

    msgdma_sink_fifo #(.DEPTH(16)) dut (
        .clk    (clk),
        .aclr_n (aclr_n),
        .clr    (clr),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mcount = 0;
    logic [32:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Monitor: every consumed head word is checked against the scoreboard
    always @(negedge clk) begin
        if (aclr_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected got=%h want=none", bus.out_data);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("out_data", bus.out_data, e[31:0]);
                chk("out_last", {31'b0, bus.out_last}, {31'b0, e[32]});
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1
    task automatic cyc(input logic v, input logic [31:0] d, input logic e,
                       input logic r, input logic c);
        logic acc, pp;
        bus.snk_valid = v;
        bus.snk_data  = d;
        bus.snk_eop   = e;
        bus.out_ready = r;
        clr           = c;
        acc = v && (mcount != 16) && !c;
        pp  = r && (mcount != 0) && !c;
        @(negedge clk);
        chk("snk_ready", {31'b0, bus.snk_ready}, {31'b0, (mcount != 16) && !c});
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, mcount != 0});
        if (acc) exp_q.push_back({e, d});
        @(posedge clk);
        if (c) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            mcount = mcount + int'(acc) - int'(pp);
        end
        #1;
    endtask

    task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
        bus.address = a;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk(nm, bus.readdata, exp);
    endtask

    initial begin
        aclr_n        = 1'b0;
        clr           = 1'b0;
        bus.snk_valid = 1'b0;
        bus.snk_data  = '0;
        bus.snk_eop   = 1'b0;
        bus.out_ready = 1'b0;
        bus.address   = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readdata", bus.readdata, 32'h0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_snk_ready", {31'b0, bus.snk_ready}, 32'h1);
        aclr_n = 1'b1;

        rd("idle_stat0", 2'd0, 32'h0001_0000);
        rd("idle_word", 2'd1, 32'h0);
        rd("idle_pkt", 2'd2, 32'h0);
        rd("idle_stall", 2'd3, 32'h0);

        cyc(1'b1, 32'h3F80_0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'h4000_0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'h4040_0000, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        rd("pkt_word", 2'd1, 32'd3);
        rd("pkt_pkt", 2'd2, 32'd1);

        // Fill: eop on the 16th accepted word so in_pkt reads back 0
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 32'hA000_0000 + i, (i == 15), 1'b0, 1'b0);
        rd("full_stat0", 2'd0, 32'h0002_0010);
        rd("full_stall", 2'd3, 32'd4);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        rd("one_pop_stat0", 2'd0, 32'h0000_000F);
        rd("full_word", 2'd1, 32'd19);

        for (int i = 0; i < 7; i++)
            cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        rd("at8_stat0", 2'd0, 32'h0000_0008);
        for (int i = 0; i < 40; i++)
            cyc(1'b1, 32'hB000_0000 + i, 1'b0, 1'b1, 1'b0);
        rd("wrap_stat0", 2'd0, 32'h0004_0008);
        rd("wrap_word", 2'd1, 32'd59);
        rd("wrap_pkt", 2'd2, 32'd2);

        for (int i = 0; i < 3; i++)
            cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        rd("pre_clr_stat0", 2'd0, 32'h0004_0005);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        rd("clr_stat0", 2'd0, 32'h0001_0000);
        rd("clr_word", 2'd1, 32'h0);
        rd("clr_pkt", 2'd2, 32'h0);
        rd("clr_stall", 2'd3, 32'h0);

        for (int i = 0; i < 7; i++)
            cyc(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, 1'b0);
        rd("pre_rst_stat0", 2'd0, 32'h0004_0007);
        aclr_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("midrst_readdata", bus.readdata, 32'h0);
        mcount = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        aclr_n = 1'b1;
        rd("post_rst_stat0", 2'd0, 32'h0001_0000);
        rd("post_rst_word", 2'd1, 32'h0);
        rd("post_rst_pkt", 2'd2, 32'h0);
        rd("post_rst_stall", 2'd3, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
